// File: rtl/rom_mem_loader.sv
// Loads a command-addressed burst of stream words into a memory core's write port.
// Addresses start at the command base and wrap modulo depth; done/err pulse at completion.
module rom_mem_loader #(
   parameter int unsigned depth    = 16,
   parameter int unsigned addrbits = 4,
   parameter int unsigned width    = 8
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [addrbits-1:0] cmd_base,
   input  logic [addrbits:0]   cmd_len,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [width-1:0]    in_data,
   input  logic                abort,
   output logic                write_en,
   output logic [addrbits-1:0] write_addr,
   output logic [width-1:0]    write_data,
   output logic                busy,
   output logic                done,
   output logic                err
);

   localparam int unsigned AW = addrbits;
   localparam int unsigned CW = addrbits + 1;
   localparam int unsigned DW = width;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      DONE = 2'd2
   } state_e;

   state_e          state_q, state_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [CW-1:0]   rem_q, rem_d;
   logic            we_q, we_d;
   logic [AW-1:0]   wa_q, wa_d;
   logic [DW-1:0]   wd_q, wd_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            err_q, err_d;
   logic            cmd_bad;

   // Base past the last word or a length longer than the memory is rejected outright.
   assign cmd_bad = ({1'b0, cmd_base} >= CW'(depth)) || (cmd_len > CW'(depth));

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      rem_d     = rem_q;
      we_d      = 1'b0;
      wa_d      = wa_q;
      wd_d      = wd_q;
      done_d    = 1'b0;
      err_d     = 1'b0;
      cmd_ready = 1'b0;
      in_ready  = 1'b0;

      case (state_q)
         IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               if (cmd_bad) begin
                  state_d = DONE;
                  err_d   = 1'b1;
               end else if (cmd_len == '0) begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d = LOAD;
                  addr_d  = cmd_base;
                  rem_d   = cmd_len;
               end
            end
         end
         LOAD: begin
            in_ready = !abort;
            if (abort) begin
               state_d = IDLE;
            end else if (in_valid) begin
               we_d   = 1'b1;
               wa_d   = addr_q;
               wd_d   = in_data;
               addr_d = (addr_q == AW'(depth - 1)) ? '0 : addr_q + AW'(1);
               rem_d  = rem_q - CW'(1);
               if (rem_q == CW'(1)) begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         addr_q  <= '0;
         rem_q   <= '0;
         we_q    <= 1'b0;
         wa_q    <= '0;
         wd_q    <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         rem_q   <= rem_d;
         we_q    <= we_d;
         wa_q    <= wa_d;
         wd_q    <= wd_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign write_en   = we_q;
   assign write_addr = wa_q;
   assign write_data = wd_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign err        = err_q;

endmodule
